bhr_spec_controller: RTL and testbench

- Sequences the global branch history register for the predictor.
- Speculatively shifts predicted directions into a speculative history at fetch.
- Tracks in-flight branches in an in-order checkpoint queue and retires them into a committed history at resolve.
- Detects mispredictions and restores the speculative history from the committed copy, with a one-cycle recovery bubble.

---
 rtl/bhr_spec_if.sv | 32 +++
 rtl/bhr_spec_controller.sv | 91 +++++++++
 tb/tb_bhr_spec_controller.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bhr_spec_if.sv
// Fetch/backend side of the branch history controller: prediction handshake, resolve, flush and history views.
// The master drives predictions and resolves. The slave is the controller and returns ready, tag and status.
interface bhr_spec_if #(
  parameter int HIST_W = 4,
  parameter int DEPTH  = 4
);
  localparam int TAG_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              pred_valid;
  logic              pred_taken;
  logic              pred_ready;
  logic [TAG_W-1:0]  pred_tag;
  logic              resolve_valid;
  logic              resolve_taken;
  logic              flush;
  logic [HIST_W-1:0] spec_hist;
  logic [HIST_W-1:0] commit_hist;
  logic              mispredict;
  logic [CNT_W-1:0]  inflight;
  logic              resolve_err;

  modport master (
    output pred_valid, pred_taken, resolve_valid, resolve_taken, flush,
    input  pred_ready, pred_tag, spec_hist, commit_hist, mispredict, inflight, resolve_err
  );

  modport slave (
    input  pred_valid, pred_taken, resolve_valid, resolve_taken, flush,
    output pred_ready, pred_tag, spec_hist, commit_hist, mispredict, inflight, resolve_err
  );
endinterface

// File: rtl/bhr_spec_controller.sv
// Branch history sequencer: speculative history at fetch, committed history at in-order resolve, restore on mispredict/flush.
// Histories and pulses update one cycle after the event. pred_ready is combinational and drops when full, recovering, flushing or mispredicting.
module bhr_spec_controller #(
  parameter int HIST_W = 4,
  parameter int DEPTH  = 4
) (
  input logic       clk,
  input logic       rst,
  bhr_spec_if.slave bus
);
  localparam int TAG_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DEPTH-1:0]  dir_q;
  logic [TAG_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [HIST_W-1:0] spec_q, commit_q, commit_d;
  logic              mis_q, err_q;

  logic res_fire, res_mis, squash, rdy, pred_fire;

  always_comb begin
    res_fire  = bus.resolve_valid && (cnt_q != '0);
    res_mis   = res_fire && (dir_q[head_q] != bus.resolve_taken);
    squash    = bus.flush || res_mis;
    rdy       = (state_q == RUN) && (cnt_q < FULL) && !bus.flush && !res_mis;
    pred_fire = bus.pred_valid && rdy;
    // A resolve retires even under flush, so the restore below sees the updated value.
    commit_d  = res_fire ? {commit_q[HIST_W-2:0], bus.resolve_taken} : commit_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (squash) state_d = RECOVER;
      RECOVER: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      dir_q    <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
      spec_q   <= '0;
      commit_q <= '0;
      mis_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      commit_q <= commit_d;
      mis_q    <= res_mis && !bus.flush;
      err_q    <= bus.resolve_valid && (cnt_q == '0);
      if (squash) begin
        spec_q <= commit_d;
        head_q <= tail_q;
        cnt_q  <= '0;
      end else begin
        if (res_fire) head_q <= head_q + TAG_W'(1);
        if (pred_fire) begin
          dir_q[tail_q] <= bus.pred_taken;
          tail_q        <= tail_q + TAG_W'(1);
          spec_q        <= {spec_q[HIST_W-2:0], bus.pred_taken};
        end
        case ({pred_fire, res_fire})
          2'b10:   cnt_q <= cnt_q + CNT_W'(1);
          2'b01:   cnt_q <= cnt_q - CNT_W'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

  assign bus.pred_ready  = rdy;
  assign bus.pred_tag    = tail_q;
  assign bus.spec_hist   = spec_q;
  assign bus.commit_hist = commit_q;
  assign bus.mispredict  = mis_q;
  assign bus.inflight    = cnt_q;
  assign bus.resolve_err = err_q;
endmodule

// File: tb/tb_bhr_spec_controller.sv
// Bench for bhr_spec_controller: a queue-based reference model feeds a scoreboard, plus directed checks per scenario.
module tb_bhr_spec_controller;
  localparam int HW = 4;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bhr_spec_if #(.HIST_W(HW), .DEPTH(DP)) bus ();
  bhr_spec_controller #(.HIST_W(HW), .DEPTH(DP)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int due; logic rdy; logic [1:0] tag;} comb_exp_t;
  typedef struct {int due; logic [3:0] spec; logic [3:0] commit; logic [2:0] infl; logic mis; logic err;} reg_exp_t;
  comb_exp_t comb_sb[$];
  reg_exp_t  reg_sb[$];
  comb_exp_t mce;
  reg_exp_t  mre;

  // Reference model state
  logic [3:0] m_spec, m_commit;
  logic [1:0] m_tail;
  logic       m_rec;
  logic       m_q[$];

  task automatic model_reset();
    m_spec = '0; m_commit = '0; m_tail = '0; m_rec = 1'b0;
    m_q.delete();
  endtask

  task automatic step(input logic pv, input logic pt, input logic rv, input logic rt, input logic fl);
    int n;
    logic rfire, mis, rdy, acc, err;
    logic [3:0] nc;
    comb_exp_t ce;
    reg_exp_t re;
    bus.pred_valid = pv; bus.pred_taken = pt;
    bus.resolve_valid = rv; bus.resolve_taken = rt; bus.flush = fl;
    n     = m_q.size();
    rfire = rv && (n > 0);
    mis   = rfire && (m_q[0] != rt);
    rdy   = !m_rec && (n < DP) && !fl && !mis;
    acc   = pv && rdy;
    err   = rv && (n == 0);
    nc    = rfire ? {m_commit[2:0], rt} : m_commit;
    ce.due = cyc; ce.rdy = rdy; ce.tag = m_tail;
    comb_sb.push_back(ce);
    m_rec = m_rec ? 1'b0 : (fl || mis);
    if (fl || mis) begin
      m_spec = nc;
      m_q.delete();
    end else begin
      if (rfire) void'(m_q.pop_front());
      if (acc) begin
        m_q.push_back(pt);
        m_tail = m_tail + 2'd1;
        m_spec = {m_spec[2:0], pt};
      end
    end
    m_commit = nc;
    re.due = cyc + 1; re.spec = m_spec; re.commit = m_commit;
    re.infl = 3'(m_q.size()); re.mis = mis && !fl; re.err = err;
    reg_sb.push_back(re);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    while (comb_sb.size() > 0 && comb_sb[0].due == cyc) begin
      mce = comb_sb.pop_front();
      checks++;
      if ({bus.pred_ready, bus.pred_tag} !== {mce.rdy, mce.tag}) begin
        failures++;
        $display("FAIL sb_ready_tag cyc=%0d got ready=%b tag=%0d expected ready=%b tag=%0d",
                 cyc, bus.pred_ready, bus.pred_tag, mce.rdy, mce.tag);
      end
    end
    while (reg_sb.size() > 0 && reg_sb[0].due == cyc) begin
      mre = reg_sb.pop_front();
      checks++;
      if ({bus.spec_hist, bus.commit_hist, bus.inflight, bus.mispredict, bus.resolve_err} !==
          {mre.spec, mre.commit, mre.infl, mre.mis, mre.err}) begin
        failures++;
        $display("FAIL sb_state cyc=%0d got spec=%h commit=%h infl=%0d mis=%b err=%b expected spec=%h commit=%h infl=%0d mis=%b err=%b",
                 cyc, bus.spec_hist, bus.commit_hist, bus.inflight, bus.mispredict, bus.resolve_err,
                 mre.spec, mre.commit, mre.infl, mre.mis, mre.err);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.pred_valid = 0; bus.pred_taken = 0; bus.resolve_valid = 0; bus.resolve_taken = 0; bus.flush = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.spec_hist, bus.commit_hist, bus.inflight, bus.mispredict, bus.resolve_err, bus.pred_ready, bus.pred_tag} !==
        {4'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL reset_state got spec=%h commit=%h infl=%0d mis=%b err=%b rdy=%b tag=%0d expected 0/0/0/0/0/1/0",
               bus.spec_hist, bus.commit_hist, bus.inflight, bus.mispredict, bus.resolve_err, bus.pred_ready, bus.pred_tag);
    end
  endtask

  task automatic test_basic();
    do_reset();
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    checks++;
    if (bus.spec_hist !== 4'h5) begin failures++; $display("FAIL basic_spec got %h expected 5", bus.spec_hist); end
    checks++;
    if (bus.commit_hist !== 4'h0) begin failures++; $display("FAIL basic_commit got %h expected 0", bus.commit_hist); end
    checks++;
    if (bus.inflight !== 3'd3) begin failures++; $display("FAIL basic_inflight got %0d expected 3", bus.inflight); end
  endtask

  task automatic test_full();
    do_reset();
    repeat (4) step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    checks++;
    if ({bus.inflight, bus.pred_ready} !== {3'd4, 1'b0}) begin
      failures++; $display("FAIL full_hold got infl=%0d rdy=%b expected infl=4 rdy=0", bus.inflight, bus.pred_ready);
    end
    step(1, 1, 1, 1, 0);
    checks++;
    if ({bus.inflight, bus.pred_ready} !== {3'd3, 1'b1}) begin
      failures++; $display("FAIL full_free got infl=%0d rdy=%b expected infl=3 rdy=1", bus.inflight, bus.pred_ready);
    end
    step(1, 1, 0, 0, 0);
    checks++;
    if (bus.inflight !== 3'd4) begin failures++; $display("FAIL full_refill got %0d expected 4", bus.inflight); end
  endtask

  task automatic test_mispredict();
    do_reset();
    repeat (3) step(1, 1, 0, 0, 0);
    checks++;
    if (bus.spec_hist !== 4'h7) begin failures++; $display("FAIL mis_pre_spec got %h expected 7", bus.spec_hist); end
    step(1, 1, 1, 0, 0);
    checks++;
    if ({bus.commit_hist, bus.spec_hist, bus.inflight, bus.mispredict, bus.pred_ready} !== {4'h0, 4'h0, 3'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL mis_recover got commit=%h spec=%h infl=%0d mis=%b rdy=%b expected 0/0/0/1/0",
               bus.commit_hist, bus.spec_hist, bus.inflight, bus.mispredict, bus.pred_ready);
    end
    step(0, 0, 0, 0, 0);
    checks++;
    if ({bus.mispredict, bus.pred_ready} !== {1'b0, 1'b1}) begin
      failures++; $display("FAIL mis_done got mis=%b rdy=%b expected mis=0 rdy=1", bus.mispredict, bus.pred_ready);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0);
    checks++;
    if ({bus.inflight, bus.commit_hist, bus.spec_hist} !== {3'd2, 4'h1, 4'h4}) begin
      failures++;
      $display("FAIL b2b got infl=%0d commit=%h spec=%h expected infl=2 commit=1 spec=4",
               bus.inflight, bus.commit_hist, bus.spec_hist);
    end
  endtask

  task automatic test_wrap();
    logic b;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.pred_tag !== 2'(i)) begin failures++; $display("FAIL wrap_tag i=%0d got %0d expected %0d", i, bus.pred_tag, i % 4); end
      b = 1'($urandom_range(0, 1));
      step(1, b, 0, 0, 0);
      step(0, 0, 1, b, 0);
    end
    checks++;
    if (bus.inflight !== 3'd0) begin failures++; $display("FAIL wrap_inflight got %0d expected 0", bus.inflight); end
  endtask

  task automatic test_empty_resolve();
    do_reset();
    step(0, 0, 1, 1, 0);
    checks++;
    if ({bus.resolve_err, bus.commit_hist, bus.spec_hist, bus.inflight} !== {1'b1, 4'h0, 4'h0, 3'd0}) begin
      failures++;
      $display("FAIL empty_res got err=%b commit=%h spec=%h infl=%0d expected 1/0/0/0",
               bus.resolve_err, bus.commit_hist, bus.spec_hist, bus.inflight);
    end
    step(0, 0, 0, 0, 0);
    checks++;
    if (bus.resolve_err !== 1'b0) begin failures++; $display("FAIL empty_res_pulse got %b expected 0", bus.resolve_err); end
  endtask

  task automatic test_flush();
    do_reset();
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    repeat (3) step(1, 1, 0, 0, 0);
    checks++;
    if ({bus.commit_hist, bus.inflight} !== {4'h2, 3'd3}) begin
      failures++; $display("FAIL flush_setup got commit=%h infl=%0d expected commit=2 infl=3", bus.commit_hist, bus.inflight);
    end
    step(0, 0, 0, 0, 1);
    checks++;
    if ({bus.spec_hist, bus.inflight, bus.mispredict, bus.pred_ready} !== {4'h2, 3'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL flush got spec=%h infl=%0d mis=%b rdy=%b expected 2/0/0/0",
               bus.spec_hist, bus.inflight, bus.mispredict, bus.pred_ready);
    end
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    do_reset();
    checks++;
    if ({bus.inflight, bus.mispredict, bus.spec_hist, bus.pred_tag} !== {3'd0, 1'b0, 4'h0, 2'd0}) begin
      failures++;
      $display("FAIL reset_mid got infl=%0d mis=%b spec=%h tag=%0d expected 0/0/0/0",
               bus.inflight, bus.mispredict, bus.spec_hist, bus.pred_tag);
    end
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    test_reset();
    test_basic();
    test_full();
    test_mispredict();
    test_back_to_back();
    test_wrap();
    test_empty_resolve();
    test_flush();
    test_random();
    test_reset_mid();
    step(0, 0, 0, 0, 0);
    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
